// File: rtl/wfg_pat_sync_pkg.sv
// Shared types and default widths for the pattern sync generator.
package wfg_pat_sync_pkg;

   localparam int unsigned WFG_SUBCYCLE_W_DEF = 16;
   localparam int unsigned WFG_SYNC_W_DEF     = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_STOP = 2'd2
   } wfg_pat_sync_state_e;

endpackage

// File: rtl/wfg_pat_sync_gen.sv
// Timing master for the pattern driver: sync pulse, subcycle strobe and subcycle index.
// Outputs are registered one stage behind the counters they describe.
module wfg_pat_sync_gen
   import wfg_pat_sync_pkg::*;
#(
   parameter int unsigned SUBCYCLE_W = WFG_SUBCYCLE_W_DEF,
   parameter int unsigned SYNC_W     = WFG_SYNC_W_DEF
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  ctrl_en_q_i,
   input  logic [SUBCYCLE_W-1:0] cfg_subcycle_q_i,
   input  logic [SYNC_W-1:0]     cfg_sync_q_i,
   output logic                  wfg_pat_sync_o,
   output logic                  wfg_pat_subcycle_o,
   output logic [SYNC_W-1:0]     wfg_pat_subcycle_cnt_o,
   output logic                  wfg_core_active_o
);

   wfg_pat_sync_state_e   state, state_nxt;
   logic [SUBCYCLE_W-1:0] clk_cnt, clk_cnt_nxt, sub_len, sub_len_nxt;
   logic [SYNC_W-1:0]     sub_cnt, sub_cnt_nxt, sync_len, sync_len_nxt;
   logic                  running, sub_end, period_end;

   always_comb begin
      running      = (state != ST_IDLE);
      sub_end      = (clk_cnt == sub_len);
      period_end   = sub_end && (sub_cnt == sync_len);
      state_nxt    = state;
      clk_cnt_nxt  = clk_cnt;
      sub_cnt_nxt  = sub_cnt;
      sub_len_nxt  = sub_len;
      sync_len_nxt = sync_len;

      case (state)
         ST_IDLE: begin
            if (ctrl_en_q_i) begin
               state_nxt    = ST_RUN;
               sub_len_nxt  = cfg_subcycle_q_i;
               sync_len_nxt = cfg_sync_q_i;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Enable dropping exactly at period end skips STOP entirely.
            if (!ctrl_en_q_i) begin
               state_nxt = period_end ? ST_IDLE : ST_STOP;
            end else begin
               state_nxt = ST_RUN;
            end
         end
         ST_STOP: begin
            if (ctrl_en_q_i) begin
               state_nxt = ST_RUN;
            end else if (period_end) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_STOP;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      if (running) begin
         if (period_end) begin
            clk_cnt_nxt  = '0;
            sub_cnt_nxt  = '0;
            sub_len_nxt  = cfg_subcycle_q_i;
            sync_len_nxt = cfg_sync_q_i;
         end else if (sub_end) begin
            clk_cnt_nxt = '0;
            sub_cnt_nxt = sub_cnt + 1'b1;
         end else begin
            clk_cnt_nxt = clk_cnt + 1'b1;
         end
      end else begin
         clk_cnt_nxt = '0;
         sub_cnt_nxt = '0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state    <= ST_IDLE;
         clk_cnt  <= '0;
         sub_cnt  <= '0;
         sub_len  <= '0;
         sync_len <= '0;
      end else begin
         state    <= state_nxt;
         clk_cnt  <= clk_cnt_nxt;
         sub_cnt  <= sub_cnt_nxt;
         sub_len  <= sub_len_nxt;
         sync_len <= sync_len_nxt;
      end
   end

   // Output stage decodes the current counters, giving one clock of latency.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         wfg_pat_sync_o         <= 1'b0;
         wfg_pat_subcycle_o     <= 1'b0;
         wfg_pat_subcycle_cnt_o <= '0;
         wfg_core_active_o      <= 1'b0;
      end else begin
         wfg_pat_sync_o         <= running && (clk_cnt == '0) && (sub_cnt == '0);
         wfg_pat_subcycle_o     <= running && (clk_cnt == '0);
         wfg_pat_subcycle_cnt_o <= running ? sub_cnt : '0;
         wfg_core_active_o      <= running;
      end
   end

endmodule

// File: tb/tb_wfg_pat_sync_gen.sv
// Directed bench for wfg_pat_sync_gen: start, reconfig, stop, reset, degenerate and one-shot runs.
module tb_wfg_pat_sync_gen;

   logic        clk;
   logic        rst;
   logic        en;
   logic [15:0] cfg_sub;
   logic [7:0]  cfg_sync;
   logic        sync_o;
   logic        sub_o;
   logic [7:0]  cnt_o;
   logic        act_o;

   int checks = 0;
   int errors = 0;

   wfg_pat_sync_gen #(
      .SUBCYCLE_W(16),
      .SYNC_W    (8)
   ) dut (
      .wb_clk_i              (clk),
      .wb_rst_i              (rst),
      .ctrl_en_q_i           (en),
      .cfg_subcycle_q_i      (cfg_sub),
      .cfg_sync_q_i          (cfg_sync),
      .wfg_pat_sync_o        (sync_o),
      .wfg_pat_subcycle_o    (sub_o),
      .wfg_pat_subcycle_cnt_o(cnt_o),
      .wfg_core_active_o     (act_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic e_sync, input logic e_sub,
                      input logic [7:0] e_cnt, input logic e_act);
      logic [10:0] obs;
      logic [10:0] exp;
      obs = {sync_o, sub_o, cnt_o, act_o};
      exp = {e_sync, e_sub, e_cnt, e_act};
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed sync=%b sub=%b idx=%0d act=%b expected sync=%b sub=%b idx=%0d act=%b",
                tag, sync_o, sub_o, cnt_o, act_o, e_sync, e_sub, e_cnt, e_act);
      end
   endtask

   // Position j within a running pattern of (sl+1) clocks per subcycle, (yl+1) subcycles per period.
   task automatic run_pat(input string tag, input int n, input int j0, input int sl, input int yl);
      int c;
      int s;
      for (int j = j0; j < j0 + n; j++) begin
         step();
         c = j % (sl + 1);
         s = (j / (sl + 1)) % (yl + 1);
         chk(tag, (c == 0) && (s == 0), (c == 0), s[7:0], 1'b1);
      end
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; cfg_sub = 16'd3; cfg_sync = 8'd2;
      step(); step();
      chk("reset", 1'b0, 1'b0, 8'd0, 1'b0);
      rst = 1'b0;
      step();
      chk("idle", 1'b0, 1'b0, 8'd0, 1'b0);

      // Basic start: one clock latency, then three 12-clock periods.
      en = 1'b1;
      step();
      chk("start_lat", 1'b0, 1'b0, 8'd0, 1'b0);
      run_pat("basic", 36, 0, 3, 2);

      // Reconfigure mid-period: old period finishes, then 4-clock periods.
      run_pat("pre_reconf", 6, 36, 3, 2);
      cfg_sub = 16'd1; cfg_sync = 8'd1;
      run_pat("old_cfg", 6, 42, 3, 2);
      run_pat("new_cfg", 8, 0, 1, 1);
      cfg_sub = 16'd3; cfg_sync = 8'd2;
      run_pat("tail_1_1", 4, 8, 1, 1);

      // Graceful stop: drop en in subcycle 1, run to period end, then idle.
      run_pat("stop_a", 5, 0, 3, 2);
      en = 1'b0;
      run_pat("stop_b", 7, 5, 3, 2);
      step();
      chk("stop_idle0", 1'b0, 1'b0, 8'd0, 1'b0);
      step();
      chk("stop_idle1", 1'b0, 1'b0, 8'd0, 1'b0);

      // Re-enable during STOP keeps the pulse train uninterrupted.
      en = 1'b1;
      step();
      chk("restart_lat", 1'b0, 1'b0, 8'd0, 1'b0);
      run_pat("reen_a", 3, 0, 3, 2);
      en = 1'b0;
      run_pat("reen_b", 4, 3, 3, 2);
      en = 1'b1;
      run_pat("reen_c", 23, 7, 3, 2);

      // Reset while index is 1.
      rst = 1'b1;
      step();
      chk("rst_mid0", 1'b0, 1'b0, 8'd0, 1'b0);
      step();
      chk("rst_mid1", 1'b0, 1'b0, 8'd0, 1'b0);
      rst = 1'b0;
      step();
      chk("rst_rel", 1'b0, 1'b0, 8'd0, 1'b0);
      run_pat("after_rst", 6, 0, 3, 2);

      // Degenerate 0/0: every clock is a sync.
      rst = 1'b1; cfg_sub = 16'd0; cfg_sync = 8'd0;
      step();
      rst = 1'b0;
      step();
      chk("degen_lat", 1'b0, 1'b0, 8'd0, 1'b0);
      run_pat("degen", 6, 0, 0, 0);

      // Single-cycle enable pulse with 1/3 runs exactly one 8-clock period.
      rst = 1'b1; en = 1'b0; cfg_sub = 16'd1; cfg_sync = 8'd3;
      step();
      rst = 1'b0;
      step();
      chk("single_idle", 1'b0, 1'b0, 8'd0, 1'b0);
      en = 1'b1;
      step();
      chk("single_lat", 1'b0, 1'b0, 8'd0, 1'b0);
      en = 1'b0;
      run_pat("single", 8, 0, 1, 3);
      step();
      chk("single_end0", 1'b0, 1'b0, 8'd0, 1'b0);
      step();
      chk("single_end1", 1'b0, 1'b0, 8'd0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wfg_pat_sync_gen.md
# wfg_pat_sync_gen

Timing master for the pattern driver. It generates the pattern-period sync pulse, the subcycle strobe and the 8-bit subcycle index consumed by the pattern driver's `pat_sync_i` / `pat_subcycle_cnt_i`. It sits directly upstream of the pattern driver on the same clock, and its configuration inputs come from a Wishbone register block.

## Interface
- `SUBCYCLE_W`, default 16: width of the subcycle-length configuration (clocks per subcycle minus 1).
- `SYNC_W`, default 8: width of the subcycle index and of the sync-length configuration; must be 8 to match the pattern driver.
- `wb_clk_i`  in  1  clock
- `wb_rst_i`  in  1  reset, synchronous, active-high
- `ctrl_en_q_i`  in  1  generator enable (level)
- `cfg_subcycle_q_i`  in  SUBCYCLE_W  clocks per subcycle minus 1
- `cfg_sync_q_i`  in  SYNC_W  subcycles per sync period minus 1
- `wfg_pat_sync_o`  out  1  one-clock pulse on the first clock of each sync period
- `wfg_pat_subcycle_o`  out  1  one-clock pulse on the first clock of each subcycle
- `wfg_pat_subcycle_cnt_o`  out  SYNC_W  current subcycle index
- `wfg_core_active_o`  out  1  high while the generator is in RUN or STOP

## Operation
- **FSM states:** IDLE, RUN, STOP.
- **IDLE**
  - Counters are 0 and all outputs are 0.
  - `ctrl_en_q_i`=1 latches both cfg inputs into shadow registers and moves the FSM to RUN.
- **RUN**
  - `clk_cnt` counts 0..`sub_len` (shadow value).
  - At `clk_cnt`==`sub_len`, `clk_cnt` wraps to 0 and `sub_cnt` increments.
  - At `sub_cnt`==`sync_len` together with `clk_cnt`==`sub_len` (period end), both counters wrap to 0 and the shadow registers reload from the cfg inputs.
- **Pulse and index outputs**
  - `wfg_pat_subcycle_o`=1 in every clock where the running `clk_cnt`==0.
  - `wfg_pat_sync_o`=1 in every clock where `clk_cnt`==0 and `sub_cnt`==0.
  - `wfg_pat_subcycle_cnt_o` = `sub_cnt`.
- **Config changes:** take effect only at a period boundary; mid-period changes are ignored until the period ends.
- **Disable from RUN:** `ctrl_en_q_i`=0 moves the FSM to STOP. Counting continues unchanged.
- **STOP**
  - At period end the FSM goes to IDLE. The clock after that shows no sync pulse, `wfg_core_active_o`=0 and the index is 0.
  - `ctrl_en_q_i`=1 before period end returns the FSM to RUN with no gap or phase change.
- **Degenerate configs**
  - `sub_len`=0 gives a subcycle pulse every clock.
  - `sub_len`=0 and `sync_len`=0 gives a sync pulse every clock.
- **Widths:** counters are `SUBCYCLE_W` / `SYNC_W` bits, unsigned, and compared with equality only, so overflow cannot occur.

## Timing
- All outputs are registered.
- **Reset:** while `wb_rst_i` is high, every output reads 0 from the next edge, state is IDLE, and counters and shadows are 0. Reset mid-period aborts immediately with no further pulse.
- **Start latency:** `ctrl_en_q_i` sampled high in IDLE at edge N gives `wfg_pat_sync_o`=`wfg_pat_subcycle_o`=1, index 0 and active=1 in the cycle after edge N+1. Exactly one clock of latency.
- **Period:** sync period = (`sync_len`+1)·(`sub_len`+1) clocks, with pulses exactly that far apart.
- **Index update:** the index changes in the same cycle as its subcycle pulse.
- **Simultaneous events:** en falling on the period-end clock means no new period starts; the next cycle is IDLE.
- **Stop timing:** the last RUN/STOP cycle is the period-end clock, and active falls on the following cycle.
- **Enable pulses:** en high for a single cycle in IDLE still runs one full period (RUN→STOP→IDLE).

## Structure
- Shared `wfg_pat_sync_pkg` holds:
  - the state enum `wfg_pat_sync_state_e` (IDLE/RUN/STOP);
  - the default widths as localparams.
- A single module with no sub-module.
  - The Wishbone register wrapper (`wfg_pat_sync_gen_top`) is a separate, later block in the same style as the other `_top` wrappers.

## Test plan
- **Basic start:** reset, `cfg_subcycle_q_i`=3, `cfg_sync_q_i`=2, en=1 at edge 10.
  - Sync at cycle 11, 23, 35.
  - Subcycle pulses every 4 clocks.
  - Index sequence 0,1,2,0.
- **Reconfig mid-period:** running with 3/2, change to 1/1 mid-period.
  - Current period completes at 12 clocks.
  - The next periods are 4 clocks with indices 0,1.
- **Graceful stop:** drop en in subcycle 1 of a 3/2 period.
  - Pulses continue to period end.
  - active=0 the next cycle, with no extra sync.
  - A re-enable during STOP yields an uninterrupted pulse train.
- **Degenerate config:** 0/0.
  - sync, subcycle and active=1 every clock.
  - Index constant 0.
- **Reset mid-run:** assert `wb_rst_i` in index 1.
  - All outputs 0 at the next edge.
  - After release with en=1, the first sync comes one clock later.
- **Single-cycle enable:** en pulse of 1 clock in IDLE with 1/3.
  - Exactly one 8-clock period runs, with one sync pulse and indices 0..3.
  - Then IDLE.
